// File: rtl/instr_reg_sched.sv
// Instruction register scheduler: round-robin arbitration of two producers onto the
// register load port, circular FIFO pointer/count management, and a 3-state read sequencer.
module instr_reg_sched #(
   parameter int NUM_ENTRIES = 32,
   parameter int AW          = 5,
   parameter int OPW         = 32,
   parameter int OPCW        = 4,
   parameter int IW          = 72
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req0_valid,
   input  logic            req1_valid,
   output logic            req0_ready,
   output logic            req1_ready,
   input  logic [OPCW-1:0] req0_opcode,
   input  logic [OPCW-1:0] req1_opcode,
   input  logic [OPW-1:0]  req0_operand_a,
   input  logic [OPW-1:0]  req1_operand_a,
   input  logic [OPW-1:0]  req0_operand_b,
   input  logic [OPW-1:0]  req1_operand_b,
   output logic            load_en,
   output logic [OPCW-1:0] opcode,
   output logic [OPW-1:0]  operand_a,
   output logic [OPW-1:0]  operand_b,
   output logic [AW-1:0]   write_pointer,
   output logic [AW-1:0]   read_pointer,
   input  logic [IW-1:0]   instruction_word,
   input  logic            rd_req,
   output logic            rd_valid,
   output logic [IW-1:0]   rd_data,
   output logic [AW:0]     count,
   output logic            full,
   output logic            empty
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d, write_pointer_q, write_pointer_d;
   logic [AW:0]     count_q, count_d;
   logic            last_grant_q, last_grant_d;
   logic            load_en_q, load_en_d;
   logic [OPCW-1:0] opcode_q, opcode_d;
   logic [OPW-1:0]  operand_a_q, operand_a_d, operand_b_q, operand_b_d;
   logic            rd_valid_q, rd_valid_d;
   logic [IW-1:0]   rd_data_q, rd_data_d;
   logic            gnt0, gnt1, full_c, empty_c, done;

   always_comb begin
      // In-flight load counts toward occupancy so a second grant can't overrun.
      full_c  = ((AW+2)'(count_q) + (AW+2)'(load_en_q)) == (AW+2)'(NUM_ENTRIES);
      empty_c = (count_q == '0);
      // last_grant_q = 1 means req1 won last; reset_n gating keeps grants low in reset.
      gnt0 = reset_n && !full_c && req0_valid && (!req1_valid || last_grant_q);
      gnt1 = reset_n && !full_c && req1_valid && (!req0_valid || !last_grant_q);

      last_grant_d    = last_grant_q;
      load_en_d       = 1'b0;
      opcode_d        = opcode_q;
      operand_a_d     = operand_a_q;
      operand_b_d     = operand_b_q;
      write_pointer_d = write_pointer_q;
      wp_d            = wp_q;
      if (gnt0 || gnt1) begin
         last_grant_d    = gnt1;
         load_en_d       = 1'b1;
         opcode_d        = gnt1 ? req1_opcode    : req0_opcode;
         operand_a_d     = gnt1 ? req1_operand_a : req0_operand_a;
         operand_b_d     = gnt1 ? req1_operand_b : req0_operand_b;
         write_pointer_d = wp_q;
         wp_d            = wp_q + AW'(1);
      end

      state_d    = state_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rp_d       = rp_q;
      done       = 1'b0;
      case (state_q)
         S_IDLE:  if (rd_req && !empty_c) state_d = S_FETCH;
         S_FETCH: state_d = S_DONE;
         S_DONE: begin
            done       = 1'b1;
            rd_data_d  = instruction_word;
            rd_valid_d = 1'b1;
            rp_d       = rp_q + AW'(1);
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      count_d = count_q;
      case ({load_en_q, done})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         wp_q            <= '0;
         rp_q            <= '0;
         write_pointer_q <= '0;
         count_q         <= '0;
         last_grant_q    <= 1'b1;
         load_en_q       <= 1'b0;
         opcode_q        <= '0;
         operand_a_q     <= '0;
         operand_b_q     <= '0;
         rd_valid_q      <= 1'b0;
         rd_data_q       <= '0;
      end else begin
         state_q         <= state_d;
         wp_q            <= wp_d;
         rp_q            <= rp_d;
         write_pointer_q <= write_pointer_d;
         count_q         <= count_d;
         last_grant_q    <= last_grant_d;
         load_en_q       <= load_en_d;
         opcode_q        <= opcode_d;
         operand_a_q     <= operand_a_d;
         operand_b_q     <= operand_b_d;
         rd_valid_q      <= rd_valid_d;
         rd_data_q       <= rd_data_d;
      end
   end

   assign req0_ready    = gnt0;
   assign req1_ready    = gnt1;
   assign load_en       = load_en_q;
   assign opcode        = opcode_q;
   assign operand_a     = operand_a_q;
   assign operand_b     = operand_b_q;
   assign write_pointer = write_pointer_q;
   assign read_pointer  = rp_q;
   assign rd_valid      = rd_valid_q;
   assign rd_data       = rd_data_q;
   assign count         = count_q;
   assign full          = full_c;
   assign empty         = empty_c;

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched with a behavioural model of the instruction register array.
module tb_instr_reg_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]  req0_opcode, req1_opcode, opcode;
   logic [31:0] req0_operand_a, req1_operand_a, req0_operand_b, req1_operand_b;
   logic [31:0] operand_a, operand_b;
   logic        load_en, rd_req, rd_valid, full, empty;
   logic [4:0]  write_pointer, read_pointer;
   logic [71:0] instruction_word, rd_data;
   logic [5:0]  count;

   logic [71:0] mem [32];
   int checks = 0;
   int failures = 0;

   instr_reg_sched dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
      .req0_operand_a(req0_operand_a), .req1_operand_a(req1_operand_a),
      .req0_operand_b(req0_operand_b), .req1_operand_b(req1_operand_b),
      .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .write_pointer(write_pointer), .read_pointer(read_pointer),
      .instruction_word(instruction_word), .rd_req(rd_req),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   assign instruction_word = mem[read_pointer];
   always @(posedge clk) if (load_en) mem[write_pointer] <= {4'h0, opcode, operand_a, operand_b};

   function automatic logic [71:0] word(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      return {4'h0, o, a, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0_valid = 0; req1_valid = 0; rd_req = 0;
      req0_opcode = 0; req1_opcode = 0;
      req0_operand_a = 0; req1_operand_a = 0; req0_operand_b = 0; req1_operand_b = 0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
   endtask

   // Issues one read request and waits (bounded) for the rd_valid strobe.
   task automatic do_read(output logic [71:0] data, output logic ok);
      rd_req = 1;
      tick();
      rd_req = 0;
      ok = 0;
      for (int n = 0; n < 6 && !ok; n++) begin
         if (rd_valid) ok = 1;
         else tick();
      end
      data = rd_data;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
      checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if ({full, load_en, rd_valid, req0_ready, req1_ready} !== 5'b0) begin failures++;
         $display("FAIL reset_flags got=%b exp=00000", {full, load_en, rd_valid, req0_ready, req1_ready}); end
      checks++; if ({write_pointer, read_pointer, opcode} !== 14'd0 || rd_data !== 72'd0) begin failures++;
         $display("FAIL reset_regs wp=%0d rp=%0d opc=%0d rd_data=%0h exp=0", write_pointer, read_pointer, opcode, rd_data); end
   endtask

   task automatic test_single();
      logic [71:0] d; logic ok;
      apply_reset();
      req0_valid = 1; req0_opcode = 4'd3; req0_operand_a = 32'd5; req0_operand_b = 32'hFFFF_FFFE;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_grant got=%b exp=10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 0;
      checks++; if (load_en !== 1'b1 || write_pointer !== 5'd0) begin failures++;
         $display("FAIL single_load load_en=%0b wp=%0d exp 1/0", load_en, write_pointer); end
      checks++; if ({opcode, operand_a, operand_b} !== {4'd3, 32'd5, 32'hFFFF_FFFE}) begin failures++;
         $display("FAIL single_fields got=%0h/%0h/%0h exp=3/5/fffffffe", opcode, operand_a, operand_b); end
      checks++; if (count !== 6'd0) begin failures++; $display("FAIL single_count_pre got=%0d exp=0", count); end
      tick();
      checks++; if (load_en !== 1'b0 || count !== 6'd1 || empty !== 1'b0) begin failures++;
         $display("FAIL single_commit load_en=%0b count=%0d empty=%0b exp 0/1/0", load_en, count, empty); end
      rd_req = 1;
      tick();
      rd_req = 0;
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_rd_early1 got=%0b exp=0", rd_valid); end
      tick();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_rd_early2 got=%0b exp=0", rd_valid); end
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== word(4'd3, 32'd5, 32'hFFFF_FFFE)) begin failures++;
         $display("FAIL single_rd rd_valid=%0b rd_data=%0h exp=1/%0h", rd_valid, rd_data, word(4'd3, 32'd5, 32'hFFFF_FFFE)); end
      checks++; if (count !== 6'd0 || empty !== 1'b1) begin failures++; $display("FAIL single_count_post count=%0d empty=%0b exp 0/1", count, empty); end
      tick();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_rd_pulse got=%0b exp=0", rd_valid); end
      d = 0; ok = 0;
   endtask

   task automatic test_round_robin();
      logic [71:0] exp_q[$];
      logic [71:0] d, e; logic ok; int g;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         g = i % 2;
         req0_valid = 1; req1_valid = 1;
         req0_opcode = 4'd1; req0_operand_a = 32'(i);      req0_operand_b = 32'd0;
         req1_opcode = 4'd2; req1_operand_a = 32'(i + 16); req1_operand_b = 32'd1;
         #1;
         checks++; if ({req0_ready, req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin failures++;
            $display("FAIL rr_grant%0d got=%b exp_req%0d", i, {req0_ready, req1_ready}, g); end
         exp_q.push_back((g == 0) ? word(4'd1, 32'(i), 32'd0) : word(4'd2, 32'(i + 16), 32'd1));
         tick();
         checks++; if (write_pointer !== 5'(i) || opcode !== ((g == 0) ? 4'd1 : 4'd2)) begin failures++;
            $display("FAIL rr_load%0d wp=%0d opc=%0d exp wp=%0d", i, write_pointer, opcode, i); end
      end
      req0_valid = 0; req1_valid = 0;
      tick();
      checks++; if (count !== 6'd4) begin failures++; $display("FAIL rr_count got=%0d exp=4", count); end
      for (int i = 0; i < 4; i++) begin
         do_read(d, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || d !== e) begin failures++; $display("FAIL rr_read%0d ok=%0b got=%0h exp=%0h", i, ok, d, e); end
         tick();
      end
   endtask

   task automatic test_full();
      logic [71:0] d; logic ok;
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         req0_valid = 1; req0_opcode = 4'(i); req0_operand_a = 32'(i); req0_operand_b = 32'(i * 3);
         tick();
      end
      req0_operand_a = 32'hAA; req0_opcode = 4'hA; req0_operand_b = 32'hBB;
      #1;
      checks++; if (full !== 1'b1 || req0_ready !== 1'b0 || count !== 6'd31 || load_en !== 1'b1) begin failures++;
         $display("FAIL full_after32 full=%0b ready=%0b count=%0d load_en=%0b exp 1/0/31/1", full, req0_ready, count, load_en); end
      tick();
      checks++; if (full !== 1'b1 || req0_ready !== 1'b0 || count !== 6'd32) begin failures++;
         $display("FAIL full_held full=%0b ready=%0b count=%0d exp 1/0/32", full, req0_ready, count); end
      do_read(d, ok);
      checks++; if (!ok || d !== word(4'd0, 32'd0, 32'd0)) begin failures++; $display("FAIL full_read ok=%0b got=%0h exp=0", ok, d); end
      checks++; if (full !== 1'b0 || req0_ready !== 1'b1) begin failures++;
         $display("FAIL full_release full=%0b ready=%0b exp 0/1", full, req0_ready); end
      tick();
      req0_valid = 0;
      checks++; if (load_en !== 1'b1 || write_pointer !== 5'd0 || operand_a !== 32'hAA) begin failures++;
         $display("FAIL full_33rd load_en=%0b wp=%0d a=%0h exp 1/0/aa", load_en, write_pointer, operand_a); end
   endtask

   task automatic test_wrap();
      logic [71:0] exp_q[$];
      logic [71:0] d, e; logic ok;
      apply_reset();
      for (int j = 0; j < 3; j++) begin
         req1_valid = 1; req1_opcode = 4'd5; req1_operand_a = 32'(100 + j); req1_operand_b = 32'(j);
         exp_q.push_back(word(4'd5, 32'(100 + j), 32'(j)));
         tick();
      end
      req1_valid = 0;
      tick();
      for (int i = 3; i < 40; i++) begin
         req1_valid = 1; req1_opcode = 4'd5; req1_operand_a = 32'(100 + i); req1_operand_b = 32'(i);
         rd_req = 1;
         exp_q.push_back(word(4'd5, 32'(100 + i), 32'(i)));
         tick();
         req1_valid = 0; rd_req = 0;
         checks++; if (load_en !== 1'b1 || write_pointer !== 5'(i % 32)) begin failures++;
            $display("FAIL wrap_wp%0d load_en=%0b got=%0d exp=%0d", i, load_en, write_pointer, i % 32); end
         tick(); tick();
         e = exp_q.pop_front();
         checks++; if (rd_valid !== 1'b1 || rd_data !== e) begin failures++;
            $display("FAIL wrap_rd%0d rd_valid=%0b got=%0h exp=%0h", i, rd_valid, rd_data, e); end
      end
      for (int j = 0; j < 3; j++) begin
         do_read(d, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || d !== e) begin failures++; $display("FAIL wrap_drain%0d ok=%0b got=%0h exp=%0h", j, ok, d, e); end
         tick();
      end
      checks++; if (read_pointer !== 5'd8 || empty !== 1'b1 || count !== 6'd0) begin failures++;
         $display("FAIL wrap_end rp=%0d empty=%0b count=%0d exp 8/1/0", read_pointer, empty, count); end
   endtask

   task automatic test_simultaneous();
      logic [71:0] d; logic ok;
      apply_reset();
      req0_valid = 1; req0_opcode = 4'd7; req0_operand_a = 32'd7; req0_operand_b = 32'd70;
      tick();
      req0_valid = 0;
      tick();
      rd_req = 1;
      tick();
      rd_req = 0;
      req0_valid = 1; req0_opcode = 4'd8; req0_operand_a = 32'd8; req0_operand_b = 32'd80;
      tick();
      req0_valid = 0;
      checks++; if (count !== 6'd1 || load_en !== 1'b1) begin failures++; $display("FAIL sim_pre count=%0d load_en=%0b exp 1/1", count, load_en); end
      tick();
      checks++; if (count !== 6'd1 || rd_valid !== 1'b1 || rd_data !== word(4'd7, 32'd7, 32'd70)) begin failures++;
         $display("FAIL sim_commit_done count=%0d rd_valid=%0b rd_data=%0h exp 1/1/%0h", count, rd_valid, rd_data, word(4'd7, 32'd7, 32'd70)); end
      tick();
      do_read(d, ok);
      checks++; if (!ok || d !== word(4'd8, 32'd8, 32'd80) || count !== 6'd0) begin failures++;
         $display("FAIL sim_second ok=%0b got=%0h count=%0d exp %0h/0", ok, d, count, word(4'd8, 32'd8, 32'd80)); end
      tick();
      rd_req = 1;
      for (int n = 0; n < 4; n++) begin
         tick();
         checks++; if (rd_valid !== 1'b0 || count !== 6'd0) begin failures++;
            $display("FAIL empty_rd_ignored%0d rd_valid=%0b count=%0d exp 0/0", n, rd_valid, count); end
      end
      rd_req = 0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req0_valid = 1; req0_opcode = 4'd9; req0_operand_a = 32'd9; req0_operand_b = 32'd9;
      tick(); tick();
      rd_req = 1;
      tick();
      #2 reset_n = 0;
      #1;
      checks++; if ({load_en, rd_valid, full, req0_ready, req1_ready} !== 5'b0 || empty !== 1'b1 || count !== 6'd0) begin failures++;
         $display("FAIL midrst_flags got=%b empty=%0b count=%0d exp 00000/1/0", {load_en, rd_valid, full, req0_ready, req1_ready}, empty, count); end
      checks++; if ({write_pointer, read_pointer, opcode} !== 14'd0 || operand_a !== 32'd0) begin failures++;
         $display("FAIL midrst_regs wp=%0d rp=%0d opc=%0d a=%0h exp 0", write_pointer, read_pointer, opcode, operand_a); end
      clear_inputs();
      tick();
      reset_n = 1;
      tick(); tick(); tick();
      checks++; if (rd_valid !== 1'b0 || count !== 6'd0) begin failures++;
         $display("FAIL midrst_discard rd_valid=%0b count=%0d exp 0/0", rd_valid, count); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      clear_inputs();
      reset_n = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
